// File: rtl/logic_unit_arbiter.sv
// Two-requester round-robin front end for a shared 32-bit logic unit (AND/OR/NOR/INV).
// One operation in flight at a time; the result returns on a registered, ID-tagged channel.

module AND32_2x1 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] y
);
    assign y = a & b;
endmodule

module OR32_2x1 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] y
);
    assign y = a | b;
endmodule

module NOR32_2x1 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] y
);
    assign y = ~(a | b);
endmodule

module INV32_1x1 (
    input  logic [31:0] a,
    output logic [31:0] y
);
    assign y = ~a;
endmodule

module logic_unit_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  r0_valid,
    output logic                  r0_ready,
    input  logic [1:0]            r0_op,
    input  logic [DATA_WIDTH-1:0] r0_a,
    input  logic [DATA_WIDTH-1:0] r0_b,
    input  logic                  r1_valid,
    output logic                  r1_ready,
    input  logic [1:0]            r1_op,
    input  logic [DATA_WIDTH-1:0] r1_a,
    input  logic [DATA_WIDTH-1:0] r1_b,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  rsp_id,
    output logic [CNT_WIDTH-1:0]  done_count
);

    // state | meaning
    // IDLE  | no operation in flight; grant is live, readies may assert
    // EXEC  | operands latched; gate outputs settle, result captured at next edge
    // RESP  | result held on rsp_* until rsp_valid && rsp_ready

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    state_t                 state;
    state_t                 state_nxt;

    logic                   ptr;        // 0: r0 wins a tie, 1: r1 wins a tie
    logic [1:0]             op_q;
    logic [DATA_WIDTH-1:0]  a_q;
    logic [DATA_WIDTH-1:0]  b_q;
    logic                   id_q;

    logic                   grant_any;
    logic                   grant_id;
    logic                   accept;
    logic                   release_rsp;

    logic [DATA_WIDTH-1:0]  and_y;
    logic [DATA_WIDTH-1:0]  or_y;
    logic [DATA_WIDTH-1:0]  nor_y;
    logic [DATA_WIDTH-1:0]  inv_y;
    logic [DATA_WIDTH-1:0]  result;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)      state_nxt = EXEC;
            EXEC:                     state_nxt = RESP;
            RESP:    if (release_rsp) state_nxt = IDLE;
            default:                  state_nxt = IDLE;
        endcase
    end

    always_comb begin
        grant_any = 1'b0;
        grant_id  = 1'b0;
        if (state == IDLE) begin
            if (r0_valid && r1_valid) begin
                grant_any = 1'b1;
                grant_id  = ptr;
            end else if (r0_valid) begin
                grant_any = 1'b1;
                grant_id  = 1'b0;
            end else if (r1_valid) begin
                grant_any = 1'b1;
                grant_id  = 1'b1;
            end
        end
        r0_ready    = grant_any && !grant_id;
        r1_ready    = grant_any &&  grant_id;
        accept      = (r0_valid && r0_ready) || (r1_valid && r1_ready);
        release_rsp = (state == RESP) && rsp_valid && rsp_ready;
    end

    // Pointer moves only on accept, always away from the requester just served.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            ptr  <= 1'b0;
            op_q <= 2'b00;
            a_q  <= '0;
            b_q  <= '0;
            id_q <= 1'b0;
        end else if (accept) begin
            ptr  <= ~grant_id;
            id_q <= grant_id;
            op_q <= grant_id ? r1_op : r0_op;
            a_q  <= grant_id ? r1_a  : r0_a;
            b_q  <= grant_id ? r1_b  : r0_b;
        end
    end

    AND32_2x1 u_and (.a(a_q), .b(b_q), .y(and_y));
    OR32_2x1  u_or  (.a(a_q), .b(b_q), .y(or_y));
    NOR32_2x1 u_nor (.a(a_q), .b(b_q), .y(nor_y));
    INV32_1x1 u_inv (.a(a_q),          .y(inv_y));

    always_comb begin
        case (op_q)
            2'b00:   result = and_y;
            2'b01:   result = or_y;
            2'b10:   result = nor_y;
            default: result = inv_y;
        endcase
    end

    // rsp_data is deliberately left untouched on release so the last result stays visible.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            rsp_valid  <= 1'b0;
            rsp_data   <= '0;
            rsp_id     <= 1'b0;
            done_count <= '0;
        end else if (state == EXEC) begin
            rsp_valid <= 1'b1;
            rsp_data  <= result;
            rsp_id    <= id_q;
        end else if (release_rsp) begin
            rsp_valid <= 1'b0;
            if (done_count != CNT_MAX) begin
                done_count <= done_count + CNT_ONE;
            end
        end
    end

    a_one_ready: assert property (@(posedge CLK) disable iff (!RST)
        !(r0_ready && r1_ready));

    a_rsp_hold: assert property (@(posedge CLK) disable iff (!RST)
        (rsp_valid && !rsp_ready) |=> (rsp_valid && $stable(rsp_data) && $stable(rsp_id)));

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Scoreboard bench for logic_unit_arbiter: spec-level model predicts grants and results,
// a separate monitor consumes expected responses as the DUT hands them over.

module tb_logic_unit_arbiter;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    always #5 CLK = ~CLK;

    logic        r0_valid = 1'b0, r1_valid = 1'b0, rsp_ready = 1'b0;
    logic [1:0]  r0_op = 2'b00, r1_op = 2'b00;
    logic [31:0] r0_a = '0, r0_b = '0, r1_a = '0, r1_b = '0;

    logic        r0_ready, r1_ready, rsp_valid, rsp_id;
    logic [31:0] rsp_data;
    logic [15:0] done_count;

    logic        s_r0_ready, s_r1_ready, s_rsp_valid, s_rsp_id;
    logic [31:0] s_rsp_data;
    logic [2:0]  s_done;

    logic_unit_arbiter #(.DATA_WIDTH(32), .CNT_WIDTH(16)) dut (
        .CLK(CLK), .RST(RST),
        .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_op(r0_op), .r0_a(r0_a), .r0_b(r0_b),
        .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_op(r1_op), .r1_a(r1_a), .r1_b(r1_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_id(rsp_id),
        .done_count(done_count)
    );

    // Narrow counter copy so saturation is reachable in a short run.
    logic_unit_arbiter #(.DATA_WIDTH(32), .CNT_WIDTH(3)) dut_s (
        .CLK(CLK), .RST(RST),
        .r0_valid(r0_valid), .r0_ready(s_r0_ready), .r0_op(r0_op), .r0_a(r0_a), .r0_b(r0_b),
        .r1_valid(r1_valid), .r1_ready(s_r1_ready), .r1_op(r1_op), .r1_a(r1_a), .r1_b(r1_b),
        .rsp_valid(s_rsp_valid), .rsp_ready(rsp_ready), .rsp_data(s_rsp_data), .rsp_id(s_rsp_id),
        .done_count(s_done)
    );

    typedef struct packed {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
    } op_t;

    typedef struct packed {
        logic        id;
        logic [31:0] data;
    } rsp_t;

    op_t  q0[$];
    op_t  q1[$];
    rsp_t exp_q[$];

    int   n_assert = 0;
    int   n_fail   = 0;

    bit   rnd_valid = 1'b0;
    int   rr_mode   = 0;
    logic rr_fixed  = 1'b1;

    int   m_phase = 0;   // 0 waiting for grant, 1 computing, 2 result offered
    bit   m_ptr   = 1'b0;
    int   m_cnt   = 0;
    logic e0, e1, g_id;

    bit          hold_valid = 1'b0;
    logic [31:0] hold_data;
    logic        hold_id;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_assert++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp_v, $time);
        end
    endtask

    function automatic logic [31:0] calc(input logic [1:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
        case (op)
            2'b00:   return a & b;
            2'b01:   return a | b;
            2'b10:   return ~(a | b);
            default: return ~a;
        endcase
    endfunction

    function automatic op_t rand_op();
        op_t o;
        o.op = 2'($urandom_range(0, 3));
        o.a  = $urandom;
        o.b  = $urandom;
        return o;
    endfunction

    // Reference model: who should be ready, when a response is due, what the count reads.
    always @(negedge CLK or negedge RST) begin
        if (!RST) begin
            m_phase = 0;
            m_ptr   = 1'b0;
            m_cnt   = 0;
            exp_q.delete();
        end else begin
            e0 = 1'b0;
            e1 = 1'b0;
            if (m_phase == 0) begin
                if (r0_valid && r1_valid) begin
                    e0 = !m_ptr;
                    e1 = m_ptr;
                end else if (r0_valid) begin
                    e0 = 1'b1;
                end else if (r1_valid) begin
                    e1 = 1'b1;
                end
            end
            chk("r0_ready", 32'(r0_ready), 32'(e0));
            chk("r1_ready", 32'(r1_ready), 32'(e1));
            chk("rsp_valid", 32'(rsp_valid), 32'(m_phase == 2));
            chk("done_count", 32'(done_count), (m_cnt > 65535) ? 32'd65535 : 32'(m_cnt));
            chk("sat_r0_ready", 32'(s_r0_ready), 32'(e0));
            chk("sat_r1_ready", 32'(s_r1_ready), 32'(e1));
            chk("sat_rsp_valid", 32'(s_rsp_valid), 32'(m_phase == 2));
            chk("sat_done_count", 32'(s_done), (m_cnt > 7) ? 32'd7 : 32'(m_cnt));
            case (m_phase)
                0: if (e0 || e1) begin
                    g_id = e1;
                    exp_q.push_back(g_id ? rsp_t'{1'b1, calc(r1_op, r1_a, r1_b)}
                                         : rsp_t'{1'b0, calc(r0_op, r0_a, r0_b)});
                    m_ptr   = !g_id;
                    m_phase = 1;
                end
                1: m_phase = 2;
                default: if (rsp_ready) begin
                    m_phase = 0;
                    m_cnt++;
                end
            endcase
        end
    end

    // Monitor: consumes expected responses on handshake and checks hold-while-stalled.
    always @(negedge CLK or negedge RST) begin
        if (!RST) begin
            hold_valid = 1'b0;
        end else begin
            if (hold_valid) begin
                chk("hold_valid", 32'(rsp_valid), 32'd1);
                chk("hold_data", rsp_data, hold_data);
                chk("hold_id", 32'(rsp_id), 32'(hold_id));
            end
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_rsp", 32'd1, 32'd0);
                end else begin
                    chk("rsp_data", rsp_data, exp_q[0].data);
                    chk("rsp_id", 32'(rsp_id), 32'(exp_q[0].id));
                    chk("sat_rsp_data", s_rsp_data, exp_q[0].data);
                    void'(exp_q.pop_front());
                end
                hold_valid = 1'b0;
            end else if (rsp_valid) begin
                hold_valid = 1'b1;
                hold_data  = rsp_data;
                hold_id    = rsp_id;
            end else begin
                hold_valid = 1'b0;
            end
        end
    end

    task automatic drive();
        r0_valid = (q0.size() > 0) && (!rnd_valid || $urandom_range(0, 3) != 0);
        if (q0.size() > 0) begin
            r0_op = q0[0].op; r0_a = q0[0].a; r0_b = q0[0].b;
        end
        r1_valid = (q1.size() > 0) && (!rnd_valid || $urandom_range(0, 3) != 0);
        if (q1.size() > 0) begin
            r1_op = q1[0].op; r1_a = q1[0].a; r1_b = q1[0].b;
        end
        case (rr_mode)
            0:       rsp_ready = 1'b1;
            1:       rsp_ready = 1'($urandom_range(0, 1));
            default: rsp_ready = rr_fixed;
        endcase
    endtask

    task automatic step();
        bit a0, a1;
        @(negedge CLK);
        a0 = r0_valid && r0_ready;
        a1 = r1_valid && r1_ready;
        @(posedge CLK);
        #1;
        if (RST && a0) void'(q0.pop_front());
        if (RST && a1) void'(q1.pop_front());
        drive();
    endtask

    task automatic drain(input int max_cycles);
        int c = 0;
        while ((q0.size() > 0 || q1.size() > 0 || exp_q.size() > 0 || m_phase != 0)
               && c < max_cycles) begin
            step();
            c++;
        end
        chk("drain_timeout", 32'(c >= max_cycles), 32'd0);
    endtask

    task automatic wait_phase(input int ph);
        int c = 0;
        while (m_phase != ph && c < 50) begin
            step();
            c++;
        end
        chk("phase_timeout", 32'(c >= 50), 32'd0);
    endtask

    task automatic pulse_reset();
        #2 RST = 1'b0;
        #1;
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_done_count", 32'(done_count), 32'd0);
        chk("rst_sat_done", 32'(s_done), 32'd0);
        chk("rst_rsp_data", rsp_data, 32'd0);
        q0.delete();
        q1.delete();
        r0_valid = 1'b0;
        r1_valid = 1'b0;
        @(posedge CLK);
        #3 RST = 1'b1;
    endtask

    initial begin
        repeat (3) @(posedge CLK);
        #1;
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_rsp_data", rsp_data, 32'd0);
        chk("reset_rsp_id", 32'(rsp_id), 32'd0);
        chk("reset_done_count", 32'(done_count), 32'd0);
        #2 RST = 1'b1;

        // Single AND from r0
        q0.push_back(op_t'{2'b00, 32'hFFFF0000, 32'h0F0F0F0F});
        drain(50);
        chk("t1_data", rsp_data, 32'h0F0F0000);
        chk("t1_count", 32'(done_count), 32'd1);

        // All four ops from r1
        for (int i = 0; i < 4; i++) q1.push_back(op_t'{2'(i), 32'h00000000, 32'hFFFFFFFF});
        drain(100);

        // Both requesters saturated with work
        for (int i = 0; i < 4; i++) begin
            q0.push_back(rand_op());
            q1.push_back(rand_op());
        end
        drain(200);

        // Backpressure in RESP with r1 waiting
        rr_mode  = 2;
        rr_fixed = 1'b0;
        q0.push_back(rand_op());
        wait_phase(2);
        q1.push_back(rand_op());
        repeat (5) step();
        rr_fixed = 1'b1;
        drain(50);

        // Reset during EXEC, then during RESP
        rr_mode = 0;
        q0.push_back(rand_op());
        wait_phase(1);
        pulse_reset();
        rr_mode  = 2;
        rr_fixed = 1'b0;
        q0.push_back(rand_op());
        wait_phase(2);
        chk("pre_rst_rsp_valid", 32'(rsp_valid), 32'd1);
        pulse_reset();
        rr_mode = 0;
        for (int i = 0; i < 2; i++) begin
            q0.push_back(rand_op());
            q1.push_back(rand_op());
        end
        drain(100);

        // Random traffic, random withdrawal and backpressure; saturates the narrow counter
        rnd_valid = 1'b1;
        rr_mode   = 1;
        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(0, 1) != 0) q0.push_back(rand_op());
            else                           q1.push_back(rand_op());
        end
        drain(3000);
        rnd_valid = 1'b0;
        rr_mode   = 0;
        for (int i = 0; i < 2; i++) q1.push_back(rand_op());
        drain(50);
        @(negedge CLK);
        chk("final_sat_count", 32'(s_done), 32'd7);
        chk("final_count", 32'(done_count), 32'(m_cnt));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
